// File: rtl/ps2_scancode_encoder_if.sv
// Key-request and scancode-byte handshake bundle for ps2_scancode_encoder.
interface ps2_scancode_encoder_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [7:0] sc;
  logic       sc_valid;
  logic       sc_ready;
  logic       busy;
  logic       dropped;

  modport slave (
    input  key_valid, key_code, sc_ready,
    output key_ready, sc, sc_valid, busy, dropped
  );

  modport master (
    output key_valid, key_code, sc_ready,
    input  key_ready, sc, sc_valid, busy, dropped
  );
endinterface

// File: rtl/ps2_scancode_encoder.sv
// Queues keypad requests and emits PS/2 Set-2 make/F0/make byte streams.
// Define PS2_ENC_EXT_EN to map key_code 11 to the extended Right-arrow sequence.
module ps2_scancode_encoder #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  ps2_scancode_encoder_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef PS2_ENC_EXT_EN
  localparam int unsigned IDX_W = 3;
`else
  localparam int unsigned IDX_W = 2;
`endif

  typedef enum logic [1:0] {IDLE, BYTE, GAP} state_t;

  state_t             state, state_n;
  logic [7:0]         sc_q, sc_n;
  logic               sc_valid_q, sc_valid_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [3:0]         code, code_n;
  logic               dropped_q;

  logic [3:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               code_ok, push, pop, refuse;

  function automatic logic [7:0] make_code(input logic [3:0] k);
    case (k)
      4'd0:    make_code = 8'h45;
      4'd1:    make_code = 8'h16;
      4'd2:    make_code = 8'h1E;
      4'd3:    make_code = 8'h26;
      4'd4:    make_code = 8'h25;
      4'd5:    make_code = 8'h2E;
      4'd6:    make_code = 8'h36;
      4'd7:    make_code = 8'h3D;
      4'd8:    make_code = 8'h3E;
      4'd9:    make_code = 8'h46;
      default: make_code = 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [3:0] k, input logic [IDX_W-1:0] i);
`ifdef PS2_ENC_EXT_EN
    if (k == 4'd11) begin
      case (i)
        3'd0:    byte_at = 8'hE0;
        3'd1:    byte_at = 8'h74;
        3'd2:    byte_at = 8'hE0;
        3'd3:    byte_at = 8'hF0;
        default: byte_at = 8'h74;
      endcase
    end else
`endif
    byte_at = (i == IDX_W'(1)) ? 8'hF0 : make_code(k);
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic [3:0] k);
`ifdef PS2_ENC_EXT_EN
    if (k == 4'd11) return IDX_W'(4);
`endif
    last_idx = IDX_W'(2);
  endfunction

  always_comb begin
    code_ok = (bus.key_code <= 4'd10);
`ifdef PS2_ENC_EXT_EN
    if (bus.key_code == 4'd11) code_ok = 1'b1;
`endif
  end

  assign push   = bus.key_valid & bus.key_ready & code_ok;
  assign refuse = bus.key_valid & (~bus.key_ready | ~code_ok);

  // Zero-gap builds skip GAP entirely and present the next byte straight after the handshake.
  always_comb begin
    state_n    = state;
    sc_n       = sc_q;
    sc_valid_n = sc_valid_q;
    idx_n      = idx;
    gap_n      = gap;
    code_n     = code;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          code_n     = mem[rd_ptr];
          idx_n      = '0;
          sc_n       = byte_at(mem[rd_ptr], '0);
          sc_valid_n = 1'b1;
          state_n    = BYTE;
        end
      end
      BYTE: begin
        if (bus.sc_ready) begin
          sc_valid_n = 1'b0;
          gap_n      = '0;
          if (GAP_CYCLES == 0) begin
            if (idx == last_idx(code)) begin
              state_n = IDLE;
            end else begin
              idx_n      = idx + 1'b1;
              sc_n       = byte_at(code, idx + 1'b1);
              sc_valid_n = 1'b1;
            end
          end else begin
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (gap == GAP_LAST) begin
          if (idx == last_idx(code)) begin
            state_n = IDLE;
          end else begin
            idx_n      = idx + 1'b1;
            sc_n       = byte_at(code, idx + 1'b1);
            sc_valid_n = 1'b1;
            state_n    = BYTE;
          end
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      sc_q       <= '0;
      sc_valid_q <= 1'b0;
      idx        <= '0;
      gap        <= '0;
      code       <= '0;
      dropped_q  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      sc_q       <= sc_n;
      sc_valid_q <= sc_valid_n;
      idx        <= idx_n;
      gap        <= gap_n;
      code       <= code_n;
      dropped_q  <= refuse;
      if (push) begin
        mem[wr_ptr] <= bus.key_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.key_ready = (count != FULL_CNT);
  assign bus.sc        = sc_q;
  assign bus.sc_valid  = sc_valid_q;
  assign bus.busy      = (state != IDLE) | (count != '0);
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_ps2_scancode_encoder.sv
// Directed bench for ps2_scancode_encoder with GAP_CYCLES=4, FIFO_DEPTH=4.
module tb_ps2_scancode_encoder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ps2_scancode_encoder_if bus ();

  ps2_scancode_encoder #(.GAP_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((bus.busy || bus.sc_valid) && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (bus.busy || bus.sc_valid) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b sc_valid=%0b after %0d cycles, required idle", bus.busy, bus.sc_valid, n);
    end
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code = 4'd1;
    bus.sc_ready = 1'b1;
    tick;
    tick;
    tick;
    reset = 1'b0;
    bus.key_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.sc !== 8'h00) begin errors++; $display("FAIL reset_sc: got %h required 00", bus.sc); end
      checks++;
      if (bus.sc_valid !== 1'b0) begin errors++; $display("FAIL reset_sc_valid: got %b required 0", bus.sc_valid); end
      checks++;
      if (bus.dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b required 0", bus.dropped); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      checks++;
      if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b required 1", bus.key_ready); end
      tick;
    end
  endtask

  task automatic test_digit_one;
    logic exp_v;
    logic [7:0] exp_b;
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd1;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      exp_v = (c == 2 || c == 7 || c == 12);
      exp_b = (c >= 7 && c < 12) ? 8'hF0 : 8'h16;
      checks++;
      if (bus.sc_valid !== exp_v) begin
        errors++; $display("FAIL digit1_valid T+%0d: got %b required %b", c, bus.sc_valid, exp_v);
      end
      if (c >= 2) begin
        checks++;
        if (bus.sc !== exp_b) begin errors++; $display("FAIL digit1_sc T+%0d: got %h required %h", c, bus.sc, exp_b); end
      end
      if (c == 16 || c == 17) begin
        checks++;
        if (bus.busy !== (c == 16)) begin
          errors++; $display("FAIL digit1_busy T+%0d: got %b required %b", c, bus.busy, (c == 16));
        end
      end
      if (c < 17) tick;
    end
    wait_idle;
  endtask

  task automatic test_enter;
    logic [7:0] exp_b [0:2];
    int k;
    exp_b[0] = 8'h5A; exp_b[1] = 8'hF0; exp_b[2] = 8'h5A;
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd10;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    k = 0;
    for (int c = 1; c <= 17; c++) begin
      checks++;
      if (bus.sc_valid !== (c == 2 || c == 7 || c == 12)) begin
        errors++; $display("FAIL enter_valid T+%0d: got %b", c, bus.sc_valid);
      end
      if (bus.sc_valid && k < 3) begin
        checks++;
        if (bus.sc !== exp_b[k]) begin errors++; $display("FAIL enter_sc byte %0d: got %h required %h", k, bus.sc, exp_b[k]); end
        k++;
      end
      if (c < 17) tick;
    end
    wait_idle;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [0:5];
    int k;
    exp_b[0] = 8'h1E; exp_b[1] = 8'hF0; exp_b[2] = 8'h1E;
    exp_b[3] = 8'h26; exp_b[4] = 8'hF0; exp_b[5] = 8'h26;
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd2;
    bus.key_valid = 1'b1;
    tick;
    bus.key_code = 4'd3;
    tick;
    bus.key_valid = 1'b0;
    k = 0;
    for (int c = 2; c <= 28; c++) begin
      checks++;
      if (bus.sc_valid !== (c == 2 || c == 7 || c == 12 || c == 18 || c == 23 || c == 28)) begin
        errors++; $display("FAIL b2b_valid T+%0d: got %b", c, bus.sc_valid);
      end
      if (bus.sc_valid && k < 6) begin
        checks++;
        if (bus.sc !== exp_b[k]) begin errors++; $display("FAIL b2b_sc byte %0d: got %h required %h", k, bus.sc, exp_b[k]); end
        k++;
      end
      if (c < 28) tick;
    end
    wait_idle;
  endtask

  task automatic test_backpressure;
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd1;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    repeat (6) tick;
    bus.sc_ready = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      if (c == 10) bus.sc_ready = 1'b1;
      checks++;
      if (bus.sc_valid !== 1'b1 || bus.sc !== 8'hF0) begin
        errors++; $display("FAIL bp_hold T+%0d: got valid=%b sc=%h required valid=1 sc=F0", c, bus.sc_valid, bus.sc);
      end
      tick;
    end
    for (int c = 11; c <= 14; c++) begin
      checks++;
      if (bus.sc_valid !== 1'b0 || bus.sc !== 8'hF0) begin
        errors++; $display("FAIL bp_gap T+%0d: got valid=%b sc=%h required valid=0 sc=F0", c, bus.sc_valid, bus.sc);
      end
      tick;
    end
    checks++;
    if (bus.sc_valid !== 1'b1 || bus.sc !== 8'h16) begin
      errors++; $display("FAIL bp_next T+15: got valid=%b sc=%h required valid=1 sc=16", bus.sc_valid, bus.sc);
    end
    wait_idle;
  endtask

  task automatic test_queue_full;
    logic [7:0] got [0:14];
    logic [7:0] exp_b;
    int n;
    logic done;
    bus.sc_ready = 1'b0;
    bus.key_code = 4'd5;
    bus.key_valid = 1'b1;
    for (int r = 0; r < 6; r++) begin
      checks++;
      if (bus.key_ready !== (r < 5)) begin
        errors++; $display("FAIL qfull_key_ready R%0d: got %b required %b", r, bus.key_ready, (r < 5));
      end
      checks++;
      if (bus.dropped !== 1'b0) begin errors++; $display("FAIL qfull_no_drop R%0d: got %b required 0", r, bus.dropped); end
      tick;
    end
    bus.key_valid = 1'b0;
    checks++;
    if (bus.dropped !== 1'b1) begin errors++; $display("FAIL qfull_drop: got %b required 1", bus.dropped); end
    bus.sc_ready = 1'b1;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.sc_valid) begin
        if (n < 15) got[n] = bus.sc;
        n++;
        tick;
      end else if (!bus.busy) begin
        done = 1'b1;
      end else begin
        tick;
      end
    end
    checks++;
    if (!done || n != 15) begin errors++; $display("FAIL qfull_count: got %0d bytes done=%b required 15", n, done); end
    for (int j = 0; j < 15 && j < n; j++) begin
      exp_b = (j % 3 == 1) ? 8'hF0 : 8'h2E;
      checks++;
      if (got[j] !== exp_b) begin errors++; $display("FAIL qfull_byte %0d: got %h required %h", j, got[j], exp_b); end
    end
    wait_idle;
  endtask

  task automatic test_invalid;
    logic [3:0] codes [0:1];
    codes[0] = 4'd12;
    codes[1] = 4'd15;
    bus.sc_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.key_code = codes[i];
      bus.key_valid = 1'b1;
      tick;
      bus.key_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++;
        if (bus.dropped !== (c == 1)) begin
          errors++; $display("FAIL invalid_dropped code %0d T+%0d: got %b required %b", codes[i], c, bus.dropped, (c == 1));
        end
        checks++;
        if (bus.sc_valid !== 1'b0 || bus.busy !== 1'b0) begin
          errors++; $display("FAIL invalid_idle code %0d T+%0d: got valid=%b busy=%b required 0/0", codes[i], c, bus.sc_valid, bus.busy);
        end
        tick;
      end
    end
  endtask

  task automatic test_ext_key;
`ifdef PS2_ENC_EXT_EN
    logic [7:0] exp_b [0:4];
    logic [7:0] got [0:4];
    int n;
    logic done;
    exp_b[0] = 8'hE0; exp_b[1] = 8'h74; exp_b[2] = 8'hE0; exp_b[3] = 8'hF0; exp_b[4] = 8'h74;
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd11;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    checks++;
    if (bus.dropped !== 1'b0) begin errors++; $display("FAIL ext_dropped: got %b required 0", bus.dropped); end
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.sc_valid) begin
        if (n < 5) got[n] = bus.sc;
        n++;
        tick;
      end else if (!bus.busy) begin
        done = 1'b1;
      end else begin
        tick;
      end
    end
    checks++;
    if (!done || n != 5) begin errors++; $display("FAIL ext_count: got %0d bytes done=%b required 5", n, done); end
    for (int j = 0; j < 5 && j < n; j++) begin
      checks++;
      if (got[j] !== exp_b[j]) begin errors++; $display("FAIL ext_byte %0d: got %h required %h", j, got[j], exp_b[j]); end
    end
    wait_idle;
`else
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd11;
    bus.key_valid = 1'b1;
    tick;
    bus.key_valid = 1'b0;
    checks++;
    if (bus.dropped !== 1'b1) begin errors++; $display("FAIL ext_off_dropped: got %b required 1", bus.dropped); end
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if (bus.sc_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL ext_off_idle T+%0d: got valid=%b busy=%b required 0/0", c, bus.sc_valid, bus.busy);
      end
      tick;
    end
`endif
  endtask

  task automatic test_reset_mid;
    bus.sc_ready = 1'b1;
    bus.key_code = 4'd1;
    bus.key_valid = 1'b1;
    tick;
    bus.key_code = 4'd7;
    tick;
    bus.key_valid = 1'b0;
    repeat (5) tick;
    checks++;
    if (bus.sc_valid !== 1'b1 || bus.sc !== 8'hF0) begin
      errors++; $display("FAIL rmid_f0 T+7: got valid=%b sc=%h required valid=1 sc=F0", bus.sc_valid, bus.sc);
    end
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (bus.sc_valid !== 1'b0 || bus.sc !== 8'h00) begin
      errors++; $display("FAIL rmid_out: got valid=%b sc=%h required valid=0 sc=00", bus.sc_valid, bus.sc);
    end
    checks++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.dropped !== 1'b0) begin
      errors++; $display("FAIL rmid_state: got key_ready=%b busy=%b dropped=%b required 1/0/0", bus.key_ready, bus.busy, bus.dropped);
    end
    for (int c = 0; c < 20; c++) begin
      tick;
      checks++;
      if (bus.sc_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rmid_quiet +%0d: got valid=%b busy=%b required 0/0", c, bus.sc_valid, bus.busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code = 4'd0;
    bus.sc_ready = 1'b1;
    test_reset;
    test_digit_one;
    test_enter;
    test_back_to_back;
    test_backpressure;
    test_queue_full;
    test_invalid;
    test_ext_key;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule

// File: doc/ps2_scancode_encoder.md
# ps2_scancode_encoder

Generates PS/2 Set-2 scancode byte sequences from keypad-level key requests: the transmit-side counterpart to the scancode-to-digit converter feeding the Luhn checker. Each queued key request becomes a full make/break byte stream (make, F0, make) on an 8-bit byte port. It sits between the on-screen/auto-entry logic and any scancode consumer: the converter directly for loopback/self-test, or a PS/2 line transmitter.

## Interface
- GAP_CYCLES, 4: idle cycles inserted after every accepted byte; 0 allowed.
- FIFO_DEPTH, 4: request queue entries; power of two, ≥2.

- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  request strobe; sampled each cycle.
- key_code  in  4  0–9 digit; 10 Enter; 11 Right arrow (macro-dependent); 12–15 invalid.
- key_ready  out  1  queue not full; combinational from occupancy.
- sc  out  8  scancode byte.
- sc_valid  out  1  sc holds a byte; wired to the converter's ps2_pressed input.
- sc_ready  in  1  consumer accepts the byte; tie high for strobe-only consumers.
- busy  out  1  FSM not IDLE or queue non-empty.
- dropped  out  1  one-cycle pulse when a request is refused.

## Operation
- Make codes: 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46, Enter=5A (hex).
- Accept: key_valid & key_ready & valid code → push key_code.
- Refuse: key_valid & (!key_ready | invalid code) → no push; dropped=1 next cycle.
- Push while full is refused even if a pop occurs the same cycle.
- FSM: IDLE → BYTE → GAP → BYTE … → IDLE. A 2-bit byte index selects make/F0/make from the popped code.
- IDLE, queue non-empty: pop, load sc with byte 0, sc_valid←1, go BYTE.
- BYTE: hold sc and sc_valid until sc_ready. On handshake, sc_valid←0 and go GAP.
- GAP: counter runs GAP_CYCLES. At expiry, load the next byte and go BYTE, or go IDLE after the last byte. With GAP_CYCLES=0, the next byte is presented in the cycle after the handshake.
- sc holds its value while sc_valid=0; it changes only on load.
- Reset values: sc=00, sc_valid=0, dropped=0, busy=0, queue empty (key_ready=1 from the first post-reset cycle), FSM IDLE, counters 0.
- Reset mid-sequence aborts immediately: remaining bytes and queued requests are discarded. A consumer may see a make with no break.
- Requests presented while reset is high are ignored; dropped is not asserted.

## Timing
- Request accepted at edge of cycle T; first byte has sc_valid=1 in cycle T+2.
- Single digit, sc_ready=1, GAP_CYCLES=4: bytes valid in cycles T+2, T+7, T+12.
- Back-to-back queued key: next first byte at T+18 (gap after the last byte, then one IDLE pop cycle).
- Per-byte cost: handshake cycle + GAP_CYCLES. Per-key cost: 3·(1+GAP)+1 cycles with no backpressure.
- Queue occupancy updates on the edge; key_ready reflects it the following cycle.

## Configuration
- PS2_ENC_EXT_EN defined: key_code 11 emits the extended sequence E0, 74, E0, F0, 74 (5 bytes, same gap rules). The byte index widens to 3 bits.
- PS2_ENC_EXT_EN undefined: key_code 11 is invalid and refused with a dropped pulse. No E0 is ever emitted.

## Test plan
- Reset, key_code=1, sc_ready=1, GAP=4 → sc=16/F0/16 with sc_valid at T+2/T+7/T+12. Looped into the converter, number=10'b0000000010 and shift low once.
- key_code=10 → 5A, F0, 5A. The converter pulses check_luhn low; number is unchanged.
- Hold sc_ready=0 for 3 cycles while the F0 byte is presented → sc=F0 and sc_valid=1 stable throughout. Handshake on release, then 16 after 4 gap cycles.
- sc_ready=0, six consecutive requests of code 5 → first popped, four queued, key_ready=0, sixth gives a dropped pulse. Releasing sc_ready yields exactly five 2E/F0/2E triples.
- key_code=12 → dropped pulse, sc_valid stays 0, busy stays 0. Assert reset one cycle after the F0 handshake → sc_valid=0, no further bytes, key_ready=1.
- key_code=11 with PS2_ENC_EXT_EN → E0, 74, E0, F0, 74. Without the macro → dropped pulse, no bytes.
